// File: rtl/tsmp_encap_engine_if.sv
// tsmp_encap_engine_if: 134-bit frame word stream in and out of the encapsulator.
interface tsmp_encap_engine_if;
  logic [133:0] iv_data;
  logic         i_data_wr;
  logic [133:0] ov_data;
  logic         o_data_wr;
  modport master (output iv_data, i_data_wr, input ov_data, o_data_wr);
  modport slave (input iv_data, i_data_wr, output ov_data, o_data_wr);
endinterface

// File: rtl/tsmp_encap_engine.sv
// tsmp_encap_engine: wraps local frames in a TSMP header with PTP TC/TS fix-up, abort handling and counters.
module tsmp_encap_engine #(
  parameter int          TIMER_W      = 19,
  parameter int          TIMER_PERIOD = 500000,
  parameter logic [15:0] TSMP_TYPE    = 16'hff01,
  parameter int          TC_WORD_IDX  = 1,
  parameter bit          TS_INSERT_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [47:0]        iv_dmac,
  input  logic [47:0]        iv_smac,
  input  logic [7:0]         iv_subtype,
  input  logic               i_frame_ptp,
  input  logic               i_timer_rst,
  input  logic [47:0]        iv_syned_global_time,
  input  logic [TIMER_W-1:0] iv_relative_time,
  tsmp_encap_engine_if.slave bus,
  output logic [31:0]        ov_frame_cnt,
  output logic [15:0]        ov_err_cnt
);
  typedef enum logic [2:0] {IDLE, MD1, HDR, BODY, FLUSH, DROP} state_t;
  localparam logic [TIMER_W:0] PER = (TIMER_W+1)'(TIMER_PERIOD);
  state_t state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W:0] elapsed;
  logic [133:0] din, hdr, tc_word, ld_word, buf_q, buf_d, out_q, out_d;
  logic wr, is_head, is_tail, wr_q, wr_d, ptp_q, ptp_d, ecnt_inc;
  logic [7:0] sub_q, sub_d;
  logic [15:0] widx_q, widx_d, ecnt_q, ecnt_d;
  logic [31:0] fcnt_q, fcnt_d;
  assign din = bus.iv_data;
  assign wr = bus.i_data_wr;
  assign is_head = wr && din[133:132] == 2'b01;
  assign is_tail = wr && din[133:132] == 2'b10;
  // residence time across a timer wrap adds one full period
  assign elapsed = (timer_q >= iv_relative_time) ? {1'b0, timer_q} - {1'b0, iv_relative_time}
                                                 : {1'b0, timer_q} + PER - {1'b0, iv_relative_time};
  assign hdr = {6'b110000, iv_smac[47:24], sub_q, iv_smac[15:0], iv_dmac, TSMP_TYPE, sub_q, 8'h00};
  assign tc_word = (ptp_q && widx_q == 16'(TC_WORD_IDX)) ? {din[133:80], din[79:16] + 64'(elapsed), din[15:0]} : din;
  assign ld_word = (ptp_q && TS_INSERT_EN && is_tail) ? {tc_word[133:48], iv_syned_global_time} : tc_word;
  assign timer_d = (i_timer_rst || timer_q == TIMER_W'(TIMER_PERIOD - 1)) ? '0 : timer_q + 1'b1;
  assign ecnt_d = (ecnt_inc && ecnt_q != 16'hffff) ? ecnt_q + 1'b1 : ecnt_q;
  assign bus.ov_data = out_q;
  assign bus.o_data_wr = wr_q;
  assign ov_frame_cnt = fcnt_q;
  assign ov_err_cnt = ecnt_q;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    wr_d = 1'b0;
    buf_d = buf_q;
    sub_d = sub_q;
    ptp_d = ptp_q;
    widx_d = widx_q;
    fcnt_d = fcnt_q;
    ecnt_inc = 1'b0;
    case (state_q)
      IDLE: if (is_head) begin
        out_d = {din[133:127], 1'b1, din[125:0]};
        wr_d = 1'b1;
        sub_d = iv_subtype;
        ptp_d = i_frame_ptp;
        widx_d = '0;
        state_d = MD1;
      end
      MD1: if (is_head) begin
        ecnt_inc = 1'b1;
        state_d = DROP;
      end else if (wr) begin
        out_d = din;
        wr_d = 1'b1;
        state_d = HDR;
      end
      HDR: if (is_head) begin
        ecnt_inc = 1'b1;
        state_d = DROP;
      end else if (is_tail) begin
        out_d = {2'b10, hdr[131:0]};
        wr_d = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        state_d = IDLE;
      end else if (wr) begin
        out_d = hdr;
        wr_d = 1'b1;
        buf_d = ld_word;
        widx_d = 16'd1;
        state_d = BODY;
      end
      BODY: if (is_head) begin
        out_d = {2'b10, buf_q[131:0]};
        wr_d = 1'b1;
        ecnt_inc = 1'b1;
        state_d = DROP;
      end else if (wr) begin
        out_d = buf_q;
        wr_d = 1'b1;
        buf_d = ld_word;
        widx_d = widx_q + {15'd0, widx_q != 16'hffff};
        state_d = is_tail ? FLUSH : BODY;
      end
      FLUSH: begin
        out_d = buf_q;
        wr_d = 1'b1;
        ecnt_inc = is_head;
        fcnt_d = is_head ? fcnt_q : fcnt_q + 1'b1;
        state_d = is_head ? DROP : IDLE;
      end
      DROP: state_d = is_tail ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      out_q <= '0;
      wr_q <= 1'b0;
      buf_q <= '0;
      sub_q <= '0;
      ptp_q <= 1'b0;
      widx_q <= '0;
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out_q <= out_d;
      wr_q <= wr_d;
      buf_q <= buf_d;
      sub_q <= sub_d;
      ptp_q <= ptp_d;
      widx_q <= widx_d;
      fcnt_q <= fcnt_d;
      ecnt_q <= ecnt_d;
    end
  end
endmodule

// File: tb/tb_tsmp_encap_engine.sv
// tb_tsmp_encap_engine: scenario tasks against a frame-level reference model of the encapsulator.
module tb_tsmp_encap_engine;
  localparam int P = 500000;
  localparam int IDX = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [47:0] dmac, smac, gtime;
  logic [7:0] subtype;
  logic ptp, timer_rst;
  logic [18:0] rel;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  tsmp_encap_engine_if bus();
  tsmp_encap_engine dut (
    .i_clk(clk), .i_rst(rst), .iv_dmac(dmac), .iv_smac(smac), .iv_subtype(subtype),
    .i_frame_ptp(ptp), .i_timer_rst(timer_rst), .iv_syned_global_time(gtime),
    .iv_relative_time(rel), .bus(bus), .ov_frame_cnt(frame_cnt), .ov_err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, exp_fc = 0, exp_ec = 0;
  int unsigned tm = 0;
  logic [133:0] got[$], exp[$], fw[$];
  int got_cyc[$], w_cyc[$];
  int unsigned w_tm[$];
  logic [47:0] w_gt[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    tm <= (rst || timer_rst || tm == P - 1) ? 0 : tm + 1;
  end
  always @(negedge clk) if (bus.o_data_wr) begin
    got.push_back(bus.ov_data);
    got_cyc.push_back(cyc);
  end
  function automatic logic [133:0] rw(input logic [1:0] tag);
    return {tag, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic void mk_frame(input int k);
    fw.delete(); w_tm.delete(); w_gt.delete(); w_cyc.delete();
    fw.push_back(rw(2'b01));
    fw.push_back(rw(2'b11));
    for (int i = 0; i < k; i++) fw.push_back(rw(i == k - 1 ? 2'b10 : 2'b11));
  endfunction
  function automatic void clear();
    got.delete(); got_cyc.delete(); exp.delete();
  endfunction
  // Expected output of the first nw words of fw; ab = cut short by a head after word nw-1
  function automatic void model(input int nw, input logic pf, input logic [7:0] sb, input int unsigned rl, input logic ab);
    logic [133:0] h, w;
    longint unsigned el;
    int k;
    k = nw - 2;
    w = fw[0];
    w[126] = 1'b1;
    exp.push_back(w);
    exp.push_back(fw[1]);
    h = {6'b110000, smac[47:24], sb, smac[15:0], dmac, 16'hff01, sb, 8'h00};
    if (k == 1 && !ab) begin
      h[133:132] = 2'b10;
      exp.push_back(h);
      return;
    end
    if (k == 0) return;
    exp.push_back(h);
    for (int i = 0; i < k; i++) begin
      w = fw[2 + i];
      if (pf && i == IDX) begin
        el = (w_tm[2 + i] >= rl) ? longint'(w_tm[2 + i] - rl) : longint'(w_tm[2 + i] + P - rl);
        w[79:16] = w[79:16] + el[63:0];
      end
      if (pf && !ab && i == k - 1) w[47:0] = w_gt[2 + i];
      if (ab && i == k - 1) w[133:132] = 2'b10;
      exp.push_back(w);
    end
  endfunction
  task automatic put(input logic [133:0] w);
    @(negedge clk);
    gtime = 48'({$urandom, $urandom});
    bus.iv_data = w;
    bus.i_data_wr = 1'b1;
    w_tm.push_back(tm);
    w_gt.push_back(gtime);
    w_cyc.push_back(cyc);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gtime = 48'({$urandom, $urandom});
      bus.iv_data = rw(2'b01);
      bus.i_data_wr = 1'b0;
    end
  endtask
  task automatic timer_to(input int unsigned t);
    @(negedge clk) timer_rst = 1'b1;
    @(negedge clk) timer_rst = 1'b0;
    for (int i = 0; i < 2000 && tm != t - 1; i++) @(negedge clk);
    checks++;
    if (tm != t - 1) begin errors++; $display("FAIL timer_align got %0d want %0d", tm, t - 1); end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.ov_data !== 134'd0) begin errors++; $display("FAIL rst_data got %h want 0", bus.ov_data); end
    if (bus.o_data_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %b want 0", bus.o_data_wr); end
    if (frame_cnt !== 32'd0) begin errors++; $display("FAIL rst_fcnt got %0d want 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_ecnt got %0d want 0", err_cnt); end
    rst = 1'b0;
    idle(2);
  endtask
  task automatic test_ptp_frame();
    clear(); ptp = 1'b1; subtype = 8'h05; rel = 19'd100;
    timer_to(347);
    mk_frame(4);
    fw[3][79:16] = 64'd1000;
    foreach (fw[i]) put(fw[i]);
    idle(5);
    model(6, 1'b1, 8'h05, 100, 1'b0);
    exp_fc++;
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL ptp_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL ptp_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() >= 7) begin
      checks += 7;
      if (got[0][126] !== 1'b1) begin errors++; $display("FAIL ptp_md0_b126 got %b want 1", got[0][126]); end
      if (got[2][31:16] !== 16'hff01) begin errors++; $display("FAIL ptp_type got %h want ff01", got[2][31:16]); end
      if (got[2][15:8] !== 8'h05) begin errors++; $display("FAIL ptp_sub got %h want 05", got[2][15:8]); end
      if (got[4][79:16] !== 64'd1250) begin errors++; $display("FAIL ptp_tc got %0d want 1250", got[4][79:16]); end
      if (got[6][47:0] !== w_gt[5]) begin errors++; $display("FAIL ptp_ts got %h want %h", got[6][47:0], w_gt[5]); end
      if (got_cyc[0] != w_cyc[0] + 1) begin errors++; $display("FAIL md_latency got %0d want %0d", got_cyc[0], w_cyc[0] + 1); end
      if (got_cyc[3] != w_cyc[2] + 2) begin errors++; $display("FAIL pl_latency got %0d want %0d", got_cyc[3], w_cyc[2] + 2); end
    end
    checks++;
    if (frame_cnt !== 32'(exp_fc)) begin errors++; $display("FAIL ptp_fcnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask
  task automatic test_wrap();
    for (int n = 0; n < 2; n++) begin
      clear(); ptp = 1'b1; subtype = 8'h21;
      rel = n == 0 ? 19'd499900 : 19'd10;
      timer_to(n == 0 ? 47 : 7);
      mk_frame(3);
      fw[3][79:16] = 64'd5000;
      foreach (fw[i]) put(fw[i]);
      idle(5);
      model(5, 1'b1, 8'h21, rel, 1'b0);
      exp_fc++;
      checks++;
      if (got.size() != exp.size()) begin errors++; $display("FAIL wrap%0d_len got %0d want %0d", n, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap%0d_word%0d got %h want %h", n, i, got[i], exp[i]); end
      end
      if (got.size() >= 5) begin
        checks++;
        if (got[4][79:16] !== (n == 0 ? 64'd5150 : 64'd5000)) begin errors++; $display("FAIL wrap%0d_tc got %0d want %0d", n, got[4][79:16], n == 0 ? 5150 : 5000); end
      end
    end
  endtask
  task automatic test_plain();
    clear(); ptp = 1'b0; subtype = 8'h07; rel = 19'($urandom_range(0, P - 1));
    mk_frame(3);
    foreach (fw[i]) put(fw[i]);
    idle(5);
    model(5, 1'b0, 8'h07, rel, 1'b0);
    exp_fc++;
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL plain_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL plain_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() >= 6) begin
      checks += 3;
      if (got[2][103:96] !== 8'h07) begin errors++; $display("FAIL plain_sub_hi got %h want 07", got[2][103:96]); end
      if (got[2][15:8] !== 8'h07) begin errors++; $display("FAIL plain_sub_lo got %h want 07", got[2][15:8]); end
      if (got[5] !== fw[4]) begin errors++; $display("FAIL plain_tail got %h want %h", got[5], fw[4]); end
    end
  endtask
  task automatic test_bubbles();
    clear(); ptp = 1'b0; subtype = 8'h3c;
    mk_frame(3);
    for (int i = 0; i < 3; i++) put(fw[i]);
    idle(3);
    for (int i = 3; i < 5; i++) put(fw[i]);
    idle(5);
    model(5, 1'b0, 8'h3c, rel, 1'b0);
    exp_fc++;
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL bub_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL bub_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() >= 4) begin
      checks++;
      if (got_cyc[3] - got_cyc[2] != 4) begin errors++; $display("FAIL bub_gap got %0d want 4", got_cyc[3] - got_cyc[2]); end
    end
  endtask
  task automatic test_abort();
    clear(); ptp = 1'b1; subtype = 8'h44; rel = 19'($urandom_range(0, 1000));
    mk_frame(3);
    for (int i = 0; i < 4; i++) put(fw[i]);
    put(rw(2'b01));
    repeat (4) put(rw(2'b11));
    put(rw(2'b10));
    idle(5);
    model(4, 1'b1, 8'h44, rel, 1'b1);
    exp_ec++;
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL abort_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL abort_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks += 2;
    if (err_cnt !== 16'(exp_ec)) begin errors++; $display("FAIL abort_ecnt got %0d want %0d", err_cnt, exp_ec); end
    if (frame_cnt !== 32'(exp_fc)) begin errors++; $display("FAIL abort_fcnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask
  task automatic test_reset_mid();
    ptp = 1'b0; subtype = 8'h11;
    mk_frame(4);
    for (int i = 0; i < 4; i++) put(fw[i]);
    @(negedge clk);
    rst = 1'b1;
    bus.i_data_wr = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.ov_data !== 134'd0) begin errors++; $display("FAIL mid_rst_data got %h want 0", bus.ov_data); end
    if (bus.o_data_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got %b want 0", bus.o_data_wr); end
    if (frame_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_fcnt got %0d want 0", frame_cnt); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_ecnt got %0d want 0", err_cnt); end
    rst = 1'b0;
    exp_fc = 0; exp_ec = 0;
    idle(2);
    clear();
    mk_frame(3);
    foreach (fw[i]) put(fw[i]);
    idle(5);
    model(5, 1'b0, 8'h11, rel, 1'b0);
    exp_fc++;
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL post_rst_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL post_rst_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++;
    if (frame_cnt !== 32'(exp_fc)) begin errors++; $display("FAIL post_rst_fcnt got %0d want %0d", frame_cnt, exp_fc); end
  endtask
  task automatic test_random();
    int k;
    clear();
    for (int f = 0; f < 12; f++) begin
      k = $urandom_range(1, 6);
      ptp = 1'($urandom);
      subtype = 8'($urandom);
      rel = 19'($urandom_range(0, P - 1));
      mk_frame(k);
      foreach (fw[i]) begin
        put(fw[i]);
        if (i < fw.size() - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle($urandom_range(1, 3));
      model(k + 2, ptp, subtype, rel, 1'b0);
      exp_fc++;
    end
    idle(5);
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rand_word%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks += 2;
    if (frame_cnt !== 32'(exp_fc)) begin errors++; $display("FAIL rand_fcnt got %0d want %0d", frame_cnt, exp_fc); end
    if (err_cnt !== 16'(exp_ec)) begin errors++; $display("FAIL rand_ecnt got %0d want %0d", err_cnt, exp_ec); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    dmac = 48'({$urandom, $urandom});
    smac = 48'({$urandom, $urandom});
    gtime = '0; subtype = '0; ptp = 1'b0; timer_rst = 1'b0; rel = '0;
    bus.iv_data = '0;
    bus.i_data_wr = 1'b0;
    test_reset();
    test_ptp_frame();
    test_wrap();
    test_plain();
    test_bubbles();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
